// File: rtl/evo_dbus_csr_master.sv
// Bridges the 8-bit AVR I/O dbus to a 32-bit Avalon-MM CSR master port.
// Latency: strobe is asserted the cycle after the CMD write; done is visible one cycle after slave completion.
// Backpressure: avm_* are held stable while avm_waitrequest is high; an abort fires after TIMEOUT_CYC cycles.
module evo_dbus_csr_master #(
    parameter int         CSR_AWIDTH  = 12,
    parameter int         CSR_DWIDTH  = 32,
    parameter logic [5:0] BASE_ADR    = 6'h20,
    parameter int         TIMEOUT_CYC = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [5:0]            adr,
    input  logic [7:0]            dbus_in,
    output logic [7:0]            dbus_out,
    input  logic                  iore,
    input  logic                  iowe,
    output logic                  io_out_en,
    output logic [CSR_AWIDTH-1:0] avm_address,
    output logic                  avm_read,
    output logic                  avm_write,
    output logic [CSR_DWIDTH-1:0] avm_writedata,
    input  logic                  avm_waitrequest,
    input  logic [CSR_DWIDTH-1:0] avm_readdata,
    input  logic                  avm_readdatavalid,
    output logic                  done_pulse
);

    localparam int CW = $clog2(TIMEOUT_CYC) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD_REQ,
        S_RD_WAIT,
        S_FIN
    } state_t;

    state_t          state;
    state_t          state_d;

    logic [7:0]      adrl_q;
    logic [3:0]      adrh_q;
    logic [31:0]     data_q;
    logic            busy;
    logic            done;
    logic            err;
    logic [CW-1:0]   tmo_cnt;

    logic [5:0]      off;
    logic            sel;
    logic            stage_we;
    logic            cmd_we;
    logic            start_wr;
    logic            start_rd;
    logic            tmo_hit;
    logic            rd_hit;
    logic            wr_d;
    logic            rd_d;
    logic            fin_ok;
    logic            abort;
    logic [15:0]     full_adr;

    // Address decode: the block spans BASE_ADR..BASE_ADR+6.
    assign off       = adr - BASE_ADR;
    assign sel       = (off <= 6'd6);
    assign io_out_en = iore && sel;
    assign stage_we  = iowe && sel && (off != 6'd6) && !busy;
    assign cmd_we    = iowe && sel && (off == 6'd6);
    // Write wins when both start bits are set.
    assign start_wr  = cmd_we && (state == S_IDLE) && dbus_in[0];
    assign start_rd  = cmd_we && (state == S_IDLE) && !dbus_in[0] && dbus_in[1];
    assign tmo_hit   = (tmo_cnt >= CW'(TIMEOUT_CYC - 1));
    // Read data is only accepted while a read is actually outstanding.
    assign rd_hit    = avm_readdatavalid &&
                       (((state == S_RD_REQ) && !avm_waitrequest) || (state == S_RD_WAIT));
    assign full_adr  = {4'b0000, adrh_q, adrl_q};

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_d;
    end

    // Next-state logic; completion takes priority over timeout in the same cycle.
    always_comb begin
        state_d = state;
        unique case (state)
            S_IDLE: begin
                if (start_wr)      state_d = S_WR;
                else if (start_rd) state_d = S_RD_REQ;
            end
            S_WR: begin
                if (!avm_waitrequest) state_d = S_FIN;
                else if (tmo_hit)     state_d = S_IDLE;
            end
            S_RD_REQ: begin
                if (!avm_waitrequest) state_d = avm_readdatavalid ? S_FIN : S_RD_WAIT;
                else if (tmo_hit)     state_d = S_IDLE;
            end
            S_RD_WAIT: begin
                if (avm_readdatavalid) state_d = S_FIN;
                else if (tmo_hit)      state_d = S_IDLE;
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode: next strobe values plus completion/abort events.
    always_comb begin
        wr_d   = (state_d == S_WR);
        rd_d   = (state_d == S_RD_REQ);
        fin_ok = (state != S_FIN) && (state_d == S_FIN);
        abort  = ((state == S_WR) || (state == S_RD_REQ) || (state == S_RD_WAIT)) &&
                 (state_d == S_IDLE);
    end

    // Staging registers, Avalon outputs, status and timeout counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            adrl_q        <= '0;
            adrh_q        <= '0;
            data_q        <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            done_pulse    <= 1'b0;
            tmo_cnt       <= '0;
            avm_read      <= 1'b0;
            avm_write     <= 1'b0;
            avm_address   <= '0;
            avm_writedata <= '0;
        end else begin
            avm_write  <= wr_d;
            avm_read   <= rd_d;
            done_pulse <= fin_ok || abort;

            if (stage_we) begin
                unique case (off)
                    6'd0:    adrl_q         <= dbus_in;
                    6'd1:    adrh_q         <= dbus_in[3:0];
                    6'd2:    data_q[7:0]    <= dbus_in;
                    6'd3:    data_q[15:8]   <= dbus_in;
                    6'd4:    data_q[23:16]  <= dbus_in;
                    6'd5:    data_q[31:24]  <= dbus_in;
                    default: ;
                endcase
            end

            if (start_wr || start_rd) begin
                busy          <= 1'b1;
                done          <= 1'b0;
                err           <= 1'b0;
                avm_address   <= full_adr[CSR_AWIDTH-1:0];
                avm_writedata <= data_q;
            end

            if (rd_hit) data_q <= avm_readdata;

            if (fin_ok) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
            if (abort) begin
                busy <= 1'b0;
                done <= 1'b1;
                err  <= 1'b1;
            end

            if ((state == S_WR) || (state == S_RD_REQ) || (state == S_RD_WAIT))
                tmo_cnt <= tmo_cnt + CW'(1);
            else
                tmo_cnt <= '0;
        end
    end

    // dbus read mux; returns the current (pre-edge) register contents.
    always_comb begin
        dbus_out = 8'h00;
        if (sel) begin
            unique case (off)
                6'd0:    dbus_out = adrl_q;
                6'd1:    dbus_out = {4'b0000, adrh_q};
                6'd2:    dbus_out = data_q[7:0];
                6'd3:    dbus_out = data_q[15:8];
                6'd4:    dbus_out = data_q[23:16];
                6'd5:    dbus_out = data_q[31:24];
                6'd6:    dbus_out = {5'b00000, err, done, busy};
                default: dbus_out = 8'h00;
            endcase
        end
    end

endmodule
